pixel_row_array: RTL and testbench

//  Behavioural-digital model of one row of PIXEL_ARRAY_WIDTH image-sensor pixels with per-pixel ramp ADC.
//  - Each pixel integrates light: its storage level discharges while exposed.
//  - Each pixel converts that level against a shared ramp and latches the shared 8-bit COUNTER code when its comparator trips.
//  - Codes are presented on a parallel row bus under READ.
//  - Driven by the sensor-level FSM: ERASE -> EXPOSE -> CONVERT -> READ.

---
 rtl/pixel_row_array.sv | 82 ++++++++
 tb/tb_pixel_row_array.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_array.sv
// One row of image-sensor pixels with per-pixel single-slope ADC.
// Exposure on VBN1 edges, conversion on RAMP edges, codes registered on clk.
module pixel_row_array #(
  parameter int PIXEL_ARRAY_WIDTH = 2,
  parameter int DV_BASE           = 1,
  parameter int DV_STEP           = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                VBN1,
  input  logic                                RAMP,
  input  logic                                RESET,
  input  logic                                ERASE,
  input  logic                                EXPOSE,
  input  logic                                READ,
  input  logic [7:0]                          COUNTER,
  output logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   DATA_OUT
);

  logic                                erase;
  logic [7:0]                          r;
  logic [8:0]                          r_inc;
  logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   mem_bus;

  assign erase = ERASE & RESET;
  assign r_inc = {1'b0, r} + 9'd1;

  // Shared ramp level; one copy serves every pixel in the row
  always_ff @(posedge RAMP or posedge reset or posedge erase) begin
    if (reset) begin
      r <= '0;
    end else if (erase) begin
      r <= '0;
    end else if (r != 8'hff) begin
      r <= r + 8'd1;
    end
  end

  for (genvar i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin : g_pix
    localparam int         DVI = DV_BASE + i * DV_STEP;
    localparam logic [7:0] DV  = (DVI > 255) ? 8'd255 : 8'(DVI);

    logic [7:0] v;
    logic [7:0] mem;
    logic       trip;

    always_ff @(posedge VBN1 or posedge reset or posedge erase) begin
      if (reset) begin
        v <= 8'hff;
      end else if (erase) begin
        v <= 8'hff;
      end else if (EXPOSE) begin
        v <= (v > DV) ? v - DV : 8'd0;
      end
    end

    // Comparator sees the pre-edge level even when VBN1 coincides
    always_ff @(posedge RAMP or posedge reset or posedge erase) begin
      if (reset) begin
        trip <= 1'b0;
        mem  <= 8'd0;
      end else if (erase) begin
        trip <= 1'b0;
        mem  <= 8'hff;
      end else if (!trip && (r_inc >= {1'b0, v})) begin
        trip <= 1'b1;
        mem  <= COUNTER;
      end
    end

    assign mem_bus[i] = mem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DATA_OUT <= '0;
    end else begin
      DATA_OUT <= READ ? mem_bus : '0;
    end
  end

endmodule

// File: tb/tb_pixel_row_array.sv
// Bench for pixel_row_array: directed sensor sequences plus
// randomized expose/convert rounds against an arithmetic model.
module tb_pixel_row_array;

  localparam int W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              VBN1 = 1'b0;
  logic              RAMP = 1'b0;
  logic              RESET = 1'b0;
  logic              ERASE = 1'b0;
  logic              EXPOSE = 1'b0;
  logic              READ = 1'b0;
  logic [7:0]        COUNTER = 8'd0;
  logic [W-1:0][7:0] DATA_OUT;

  int vectors = 0;
  int miscompares = 0;

  int mv[W];
  int mm[W];
  bit mt[W];
  int dv[W];
  int mr;

  always #5 clk = ~clk;

  pixel_row_array #(
    .PIXEL_ARRAY_WIDTH(W),
    .DV_BASE(1),
    .DV_STEP(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .VBN1(VBN1),
    .RAMP(RAMP),
    .RESET(RESET),
    .ERASE(ERASE),
    .EXPOSE(EXPOSE),
    .READ(READ),
    .COUNTER(COUNTER),
    .DATA_OUT(DATA_OUT)
  );

  task automatic check(string tag, logic [7:0] obs, logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic m_clear(int mval);
    for (int i = 0; i < W; i++) begin
      mv[i] = 255;
      mt[i] = 1'b0;
      mm[i] = mval;
    end
    mr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    m_clear(0);
  endtask

  task automatic do_erase();
    RESET = 1'b1;
    ERASE = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ERASE = 1'b0;
    m_clear(255);
  endtask

  // One strobe event; VBN1 and RAMP may rise together
  task automatic step(bit ve, bit re, logic [7:0] code);
    COUNTER = code;
    #1;
    VBN1 = ve;
    RAMP = re;
    #1;
    if (re) begin
      for (int i = 0; i < W; i++) begin
        if (!mt[i] && (mr + 1 >= mv[i])) begin
          mm[i] = code;
          mt[i] = 1'b1;
        end
      end
      mr = (mr < 255) ? mr + 1 : 255;
    end
    if (ve && EXPOSE) begin
      for (int i = 0; i < W; i++) begin
        mv[i] = (mv[i] > dv[i]) ? mv[i] - dv[i] : 0;
      end
    end
    VBN1 = 1'b0;
    RAMP = 1'b0;
    #1;
  endtask

  task automatic expose(int n);
    EXPOSE = 1'b1;
    repeat (n) step(1'b1, 1'b0, 8'd0);
    EXPOSE = 1'b0;
  endtask

  task automatic ramp(int n);
    for (int k = 1; k <= n; k++) begin
      step(1'b0, 1'b1, 8'(k));
    end
  endtask

  task automatic read_exp(string tag, int e0, int e1);
    READ = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "[0]"}, DATA_OUT[0], 8'(e0));
    check({tag, "[1]"}, DATA_OUT[1], 8'(e1));
    READ = 1'b0;
  endtask

  task automatic read_model(string tag);
    READ = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s[%0d]", tag, i), DATA_OUT[i], 8'(mm[i]));
    end
    READ = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin
      dv[i] = (1 + i > 255) ? 255 : 1 + i;
    end
    m_clear(0);

    #2;
    reset = 1'b1;
    READ = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out[0]", DATA_OUT[0], 8'd0);
    check("rst_out[1]", DATA_OUT[1], 8'd0);
    reset = 1'b0;
    READ = 1'b0;
    m_clear(0);
    read_exp("rst_mem", 0, 0);

    do_erase();
    expose(10);
    ramp(255);
    read_exp("basic", 245, 235);
    @(posedge clk);
    #1;
    check("read_low", DATA_OUT[0], 8'd0);

    RESET = 1'b0;
    ERASE = 1'b1;
    repeat (3) @(posedge clk);
    read_exp("erase_gated", 245, 235);
    RESET = 1'b1;
    #1;
    read_exp("erase_held", 255, 255);
    ERASE = 1'b0;
    m_clear(255);

    do_erase();
    expose(300);
    step(1'b0, 1'b1, 8'd1);
    read_exp("saturate", 1, 1);

    do_erase();
    ramp(100);
    read_exp("no_expose", 255, 255);

    do_erase();
    EXPOSE = 1'b0;
    repeat (20) step(1'b1, 1'b0, 8'd0);
    expose(10);
    ramp(255);
    read_exp("expose_gate", 245, 235);

    do_erase();
    expose(10);
    ramp(50);
    do_reset();
    read_exp("mid_reset", 0, 0);
    do_erase();
    expose(10);
    ramp(255);
    read_exp("recover", 245, 235);

    for (int rnd = 0; rnd < 8; rnd++) begin
      int ne;
      int nr;
      do_erase();
      ne = $urandom_range(0, 300);
      nr = $urandom_range(0, 260);
      for (int k = 0; k < ne; k++) begin
        EXPOSE = ($urandom_range(0, 3) != 0);
        step(1'b1, 1'b0, 8'd0);
      end
      EXPOSE = 1'b0;
      for (int k = 0; k < nr; k++) begin
        step(1'b0, 1'b1, 8'($urandom));
      end
      read_model($sformatf("rand%0d", rnd));
    end

    for (int rnd = 0; rnd < 4; rnd++) begin
      do_erase();
      EXPOSE = 1'b1;
      for (int k = 0; k < 400; k++) begin
        step(1'($urandom), 1'($urandom), 8'($urandom));
      end
      EXPOSE = 1'b0;
      read_model($sformatf("mixed%0d", rnd));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
